// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan decoder: digit count,
// nibble width and the sixteen active-high segment patterns for hex 0..F.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NIBBLE_W   = 4;
    localparam int SEG_W      = 7;
    localparam int NUM_PATS   = 16;

    // Index k of this table is the hex value whose glyph is SEG_PATTERNS[k]
    // (bit0 = segment a ... bit6 = segment g).
    localparam logic [SEG_W-1:0] SEG_PATTERNS [NUM_PATS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to hex-nibble decoder. Patterns outside
// the sixteen known glyphs report valid = 0 and nibble = 0.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0]    seg_i,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                valid
);

    // Linear table search; the glyphs are unique so at most one entry hits.
    always_comb begin
        nibble = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_PATS; k++) begin
            if (seg_i == SEG_PATTERNS[k]) begin
                nibble = NIBBLE_W'(k);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Reconstructs six hex digits from a multiplexed seven-segment display bus.
// Inputs are sampled once, must hold STABLE_CYCLES before capture, and each
// digit goes stale TIMEOUT_CYCLES after its last capture.
// Optional: define SEVEN_SEG_DP_CAPTURE_EN to add the Points output that
// records the decimal point of each valid capture.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [7:0]                     SevenSegsAndPoint,
    input  logic [NUM_DIGITS-1:0]          ShowOneofSix,
    output logic [NUM_DIGITS*NIBBLE_W-1:0] Data,
    output logic [NUM_DIGITS-1:0]          DigitValid,
    output logic                           FrameDone,
    output logic                           PatternError,
    output logic                           SelectError
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    ,
    output logic [NUM_DIGITS-1:0]          Points
`endif
);

    localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       CNT_SAT    = 4'd15;
    localparam logic [3:0]       STABLE_CNT = 4'(STABLE_CYCLES);

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    logic [NUM_DIGITS-1:0]          sel_q;
    logic [SEG_W-1:0]               seg_q;
    logic [3:0]                     cnt_q, cnt_d;
    logic                           cap_q, cap_d;
    logic                           changed;
    logic [NUM_DIGITS*NIBBLE_W-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]          valid_q, valid_d;
    logic [NUM_DIGITS-1:0]          seen_q, seen_d;
    logic [TMO_W-1:0]               tmo_q [NUM_DIGITS];
    logic [TMO_W-1:0]               tmo_d [NUM_DIGITS];
    logic                           perr_q, perr_d;
    logic                           serr_q, serr_d;
    logic [NIBBLE_W-1:0]            dec_nibble;
    logic                           dec_valid;
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    logic                           dp_q;
    logic [NUM_DIGITS-1:0]          points_q, points_d;
`else
    logic                           unused_dp;
    assign unused_dp = SevenSegsAndPoint[7];
`endif

    seg_pattern_decode u_decode (
        .seg_i  (seg_q),
        .nibble (dec_nibble),
        .valid  (dec_valid)
    );

    // Stability counter tracks the incoming pair against the sampled one;
    // the capture flag is raised once, when the count first reaches the target.
    always_comb begin
        changed = ({ShowOneofSix, SevenSegsAndPoint[SEG_W-1:0]} != {sel_q, seg_q});
        cnt_d   = changed ? 4'd1 : ((cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 4'd1);
        cap_d   = (cnt_d == STABLE_CNT) && (changed || (cnt_d != cnt_q));
    end

    // Digit state update: timeouts and frame clear first, capture overrides.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
`ifdef SEVEN_SEG_DP_CAPTURE_EN
        points_d = points_q;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            tmo_d[i] = (tmo_q[i] == TMO_MAX) ? TMO_MAX : tmo_q[i] + TMO_W'(1);
            if (tmo_q[i] >= TMO_LAST) begin
                valid_d[i] = 1'b0;
            end
        end
        if (seen_q == '1) begin
            seen_d = '0;
        end
        if (cap_q && (sel_q != '0)) begin
            if (!is_onehot(sel_q)) begin
                serr_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        if (dec_valid) begin
                            data_d[i*NIBBLE_W +: NIBBLE_W] = dec_nibble;
                            valid_d[i] = 1'b1;
                            tmo_d[i]   = '0;
                            seen_d[i]  = 1'b1;
`ifdef SEVEN_SEG_DP_CAPTURE_EN
                            points_d[i] = dp_q;
`endif
                        end else begin
                            perr_d     = 1'b1;
                            valid_d[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // State registers with asynchronous clear of everything, data included.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sel_q   <= '0;
            seg_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                tmo_q[i] <= '0;
            end
`ifdef SEVEN_SEG_DP_CAPTURE_EN
            dp_q     <= 1'b0;
            points_q <= '0;
`endif
        end else begin
            sel_q   <= ShowOneofSix;
            seg_q   <= SevenSegsAndPoint[SEG_W-1:0];
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            tmo_q   <= tmo_d;
`ifdef SEVEN_SEG_DP_CAPTURE_EN
            dp_q     <= SevenSegsAndPoint[7];
            points_q <= points_d;
`endif
        end
    end

    assign Data         = data_q;
    assign DigitValid   = valid_q;
    assign FrameDone    = (seen_q == '1);
    assign PatternError = perr_q;
    assign SelectError  = serr_q;
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    assign Points       = points_q;
`endif

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1, range 1..15; consecutive cycles a select/pattern pair must hold before capture.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, range 2..1023; cycles without capture before a digit is declared stale.
REQ-003 SHALL have port Clock, input, 1, rising-edge clock.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port SevenSegsAndPoint, input, 8, segments; bit0=a..bit6=g, active-high lit; bit7=decimal point.
REQ-006 SHALL have port ShowOneofSix, input, 6, one-hot digit select; all-zero means blank.
REQ-007 SHALL have port Data, output, 24, reconstructed hex digits; digit i is in bits [4i+3:4i].
REQ-008 SHALL have port DigitValid, output, 6, bit i high while digit i is fresh and decoded.
REQ-009 SHALL have port FrameDone, output, 1, one-cycle pulse when a full frame has been captured.
REQ-010 SHALL have port PatternError, output, 1, one-cycle pulse on an undecodable pattern.
REQ-011 SHALL have port SelectError, output, 1, one-cycle pulse on a multi-hot select.

Function
REQ-012 SHALL register both inputs through one sampling stage before any decision.
REQ-013 SHALL decode these patterns to hex 0..F, in order: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; any other 7-bit value is invalid.
REQ-014 SHALL run a stability counter:
- resets to 1 when the sampled {select, seg[6:0]} changes;
- otherwise increments, saturating at 15;
- capture fires once, on the cycle the count equals STABLE_CYCLES.
REQ-015 On capture with a one-hot select i and a valid pattern, SHALL:
- write the nibble to Data digit i;
- set DigitValid[i];
- reset timeout counter i;
- set seen-mask bit i.
REQ-016 On capture with a one-hot select and an invalid pattern, SHALL pulse PatternError, clear DigitValid[i], and leave Data digit i unchanged.
REQ-017 On capture with a multi-hot select, SHALL pulse SelectError and change no data, valid or seen state.
REQ-018 An all-zero select SHALL cause no capture and no error.
REQ-019 Latency: with STABLE_CYCLES=1, Data/DigitValid SHALL update on the 2nd rising edge after the inputs are presented; each extra stable cycle adds one edge.
REQ-020 Per-digit timeout counters SHALL increment every cycle and saturate. On reaching TIMEOUT_CYCLES, DigitValid[i] SHALL clear; Data digit i SHALL hold its value.
REQ-021 If capture and timeout hit the same digit in the same cycle, capture SHALL win.
REQ-022 When the seen mask equals 6'h3F, SHALL pulse FrameDone for one cycle and clear the mask in that same cycle.
REQ-023 A capture in the FrameDone cycle SHALL set its seen bit into the cleared mask.

Reset
REQ-024 On Reset SHALL immediately set all to zero: Data, DigitValid, FrameDone, PatternError, SelectError, sampling registers, stability counter, timeout counters, seen mask.
REQ-025 Reset mid-frame SHALL discard the partial frame; no FrameDone results from pre-reset captures.

Configuration
REQ-026 With SEVEN_SEG_DP_CAPTURE_EN defined:
- SHALL add output Points[5:0], reset 0;
- SHALL capture bit7 into Points[i] on every valid capture of digit i.
REQ-027 Without SEVEN_SEG_DP_CAPTURE_EN: Points SHALL be absent and bit7 SHALL be ignored.

Structure
REQ-028 The 16 segment-pattern constants, NUM_DIGITS=6 and the digit nibble width SHALL live in shared package seven_seg_pkg.
REQ-029 Pattern-to-nibble decoding SHALL be combinational sub-module seg_pattern_decode, with outputs nibble[3:0] and valid.

Verification
REQ-030 Drive select 000001..100000 for one cycle each with patterns for 6,5,4,3,2,1 -> Data=24'h123456, DigitValid=6'h3F, exactly one FrameDone pulse.
REQ-031 Drive seg 7'h3F with select 6'b000100 -> Data[11:8]=4'h0, DigitValid[2]=1 two edges later.
REQ-032 Drive seg 7'h01 with select 6'b000001 after digit0=4'h9 -> one PatternError pulse, DigitValid[0]=0, Data[3:0]=4'h9.
REQ-033 Drive select 6'b000011 -> one SelectError pulse, Data and DigitValid unchanged.
REQ-034 Refresh only digits 0..4 with TIMEOUT_CYCLES=64 -> DigitValid[5] drops 64 cycles after its last capture, no FrameDone.
REQ-035 Assert Reset after 3 of 6 digits -> all outputs 0; next full 6-digit scan gives exactly one FrameDone.
